// File: rtl/range_seq_ctrl.sv
// range_seq_ctrl: session sequencer in front of the 8-bit range finder.
// Accepts a start command with a window length, pulls that many samples
// from a valid/ready stream, and presents them to the range finder as one
// unbroken go window. Stalls in the sample stream are absorbed by holding
// go high and repeating the last sample, which cannot change min/max.
// It then waits for finish under a timeout and returns the result via a
// valid/ready port.
module range_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] win_len,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             rf_go,
  output logic [WIDTH-1:0] rf_data,
  input  logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic [WIDTH-1:0] res_range,
  output logic             res_error,
  output logic             res_timeout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  // The wait counter only ever holds 0..TIMEOUT-1.
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] cnt;
  logic [WIDTH-1:0] data_reg;
  logic [TMO_W-1:0] tmo;
  logic             xfer;

  // Outputs are pure decodes of registered state, so no input reaches an
  // output combinationally.
  always_comb begin
    rf_go     = (state == STREAM);
    rf_data   = data_reg;
    s_ready   = (state == FIRST) || ((state == STREAM) && (cnt != len_reg));
    res_valid = (state == DONE);
    busy      = (state != IDLE);
    xfer      = s_valid && s_ready;
  end

  // Session FSM together with its counters and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_reg     <= '0;
      cnt         <= '0;
      data_reg    <= '0;
      tmo         <= '0;
      res_range   <= '0;
      res_error   <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (win_len != '0) begin
              len_reg <= win_len;
              cnt     <= '0;
              state   <= FIRST;
            end else begin
              // An empty window is reported as an error without ever
              // raising go at the range finder.
              res_range   <= '0;
              res_error   <= 1'b1;
              res_timeout <= 1'b0;
              state       <= DONE;
            end
          end
        end

        FIRST: begin
          // go only rises once the first sample is in hand, so the window
          // never starts with stale data.
          if (xfer) begin
            data_reg <= s_data;
            cnt      <= {{(LEN_W-1){1'b0}}, 1'b1};
            state    <= STREAM;
          end
        end

        STREAM: begin
          if (cnt == len_reg) begin
            tmo   <= '0;
            state <= WAIT;
          end else if (xfer) begin
            data_reg <= s_data;
            cnt      <= cnt + 1'b1;
          end
        end

        WAIT: begin
          if (rf_finish) begin
            res_range   <= rf_range;
            res_error   <= rf_error;
            res_timeout <= 1'b0;
            state       <= DONE;
          end else if (tmo == TMO_LAST) begin
            res_range   <= '0;
            res_error   <= 1'b1;
            res_timeout <= 1'b1;
            state       <= DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_seq_ctrl.sv
// Scoreboard bench for range_seq_ctrl: expected rf_data beats and results
// are queued as stimulus is driven and consumed by a negedge monitor.
module tb_range_seq_ctrl;

  localparam int WIDTH   = 8;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] win_len;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic             rf_go;
  logic [WIDTH-1:0] rf_data;
  logic             rf_finish;
  logic [WIDTH-1:0] rf_range;
  logic             rf_error;
  logic [WIDTH-1:0] res_range;
  logic             res_error;
  logic             res_timeout;
  logic             res_valid;
  logic             res_ready;
  logic             busy;

  range_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .rf_go(rf_go), .rf_data(rf_data), .rf_finish(rf_finish),
    .rf_range(rf_range), .rf_error(rf_error),
    .res_range(res_range), .res_error(res_error), .res_timeout(res_timeout),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  typedef struct {
    logic [WIDTH-1:0] range;
    logic             err;
    logic             tmo;
  } res_t;

  logic [WIDTH-1:0] exp_rf[$];
  res_t             exp_res[$];
  logic [WIDTH-1:0] smp[16];

  int n_checks = 0;
  int n_fail   = 0;
  int go_rises = 0;
  int res_seen = 0;
  bit model_en = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d @%0t", tag, got, $time);
    end
  endtask

  // Range-finder model: tracks min/max while go is high, pulses finish two
  // cycles after go falls with range = max - min.
  initial begin
    logic             prev_go = 1'b0;
    logic [WIDTH-1:0] mn = '0;
    logic [WIDTH-1:0] mx = '0;
    int               down = 0;
    rf_finish = 1'b0;
    rf_range  = '0;
    rf_error  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rf_finish = 1'b0;
      if (down > 0) begin
        down--;
        if (down == 0) begin
          rf_finish = 1'b1;
          rf_range  = mx - mn;
        end
      end
      if (rf_go === 1'b1 && !prev_go) begin
        mn = rf_data;
        mx = rf_data;
      end else if (rf_go === 1'b1) begin
        if (rf_data < mn) mn = rf_data;
        if (rf_data > mx) mx = rf_data;
      end
      if (rf_go !== 1'b1 && prev_go && model_en) down = 2;
      prev_go = (rf_go === 1'b1);
    end
  end

  // Monitor: every go cycle consumes one expected rf_data beat, every
  // rising res_valid consumes one expected result.
  initial begin
    logic prev_go = 1'b0;
    logic prev_rv = 1'b0;
    res_t r;
    forever begin
      @(negedge clk);
      if (rf_go === 1'b1) begin
        if (!prev_go) go_rises++;
        if (exp_rf.size() == 0) check("rf_go_unexpected", 1, 0);
        else check("rf_data", 32'(rf_data), 32'(exp_rf.pop_front()));
      end
      if (res_valid === 1'b1 && !prev_rv) begin
        res_seen++;
        if (exp_res.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          r = exp_res.pop_front();
          check("res_range", 32'(res_range), 32'(r.range));
          check("res_error", 32'(res_error), 32'(r.err));
          check("res_timeout", 32'(res_timeout), 32'(r.tmo));
        end
      end
      prev_go = (rf_go === 1'b1);
      prev_rv = (res_valid === 1'b1);
    end
  end

  // Offer one sample from a negedge and return at the negedge after it transfers.
  task automatic push_sample(input logic [WIDTH-1:0] d);
    int k = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("s_ready_wait", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Full session of n samples from smp[], 'gap' idle cycles between samples.
  task automatic run_window(input int n, input int gap, input bit with_finish, input int exp_lat);
    res_t             r;
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] mx;
    int               rises0;
    int               k;
    int               lat;
    mn = smp[0];
    mx = smp[0];
    for (int i = 0; i < n; i++) begin
      if (smp[i] < mn) mn = smp[i];
      if (smp[i] > mx) mx = smp[i];
      for (int j = 0; j < ((i == n - 1) ? 1 : gap + 1); j++) exp_rf.push_back(smp[i]);
    end
    r.range = with_finish ? (mx - mn) : '0;
    r.err   = !with_finish;
    r.tmo   = !with_finish;
    exp_res.push_back(r);
    rises0 = go_rises;

    start   = 1'b1;
    win_len = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
    check("first_s_ready", 32'(s_ready), 1);
    for (int i = 0; i < n; i++) begin
      push_sample(smp[i]);
      if (i < n - 1) repeat (gap) @(negedge clk);
    end
    k = 0;
    while (rf_go === 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("go_fall_wait", 0, 1);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("res_latency", 32'(lat), 32'(exp_lat));
    check("window_beats_left", 32'(exp_rf.size()), 0);
    check("window_go_rises", 32'(go_rises - rises0), 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("handshake_res_valid", 32'(res_valid), 0);
    check("handshake_busy", 32'(busy), 0);
  endtask

  initial begin
    int rises0;
    int seen0;
    rst_n     = 1'b0;
    start     = 1'b1;
    s_valid   = 1'b1;
    s_data    = 8'hA5;
    win_len   = 4'd3;
    res_ready = 1'b0;

    // Reset held for two edges with start and s_valid active.
    repeat (2) @(negedge clk);
    check("rst_rf_go", 32'(rf_go), 0);
    check("rst_rf_data", 32'(rf_data), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_res_range", 32'(res_range), 0);
    check("rst_res_error", 32'(res_error), 0);
    check("rst_res_timeout", 32'(res_timeout), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_busy", 32'(busy), 0);
    start   = 1'b0;
    s_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);

    // Continuous window 10,3,7,20 -> range 17.
    smp[0] = 8'd10; smp[1] = 8'd3; smp[2] = 8'd7; smp[3] = 8'd20;
    run_window(4, 0, 1'b1, 3);

    // Gapped window 5,9,1 with two idle cycles between samples.
    smp[0] = 8'd5; smp[1] = 8'd9; smp[2] = 8'd1;
    run_window(3, 2, 1'b1, 3);

    // Timeout: finish never arrives.
    model_en = 1'b0;
    smp[0] = 8'd4; smp[1] = 8'd8;
    run_window(2, 0, 1'b0, TIMEOUT);
    model_en = 1'b1;
    repeat (4) @(negedge clk);

    // Zero-length window: immediate error result, no go.
    rises0  = go_rises;
    exp_res.push_back('{range: '0, err: 1'b1, tmo: 1'b0});
    start   = 1'b1;
    win_len = '0;
    @(negedge clk);
    start = 1'b0;
    check("zero_len_res_valid", 32'(res_valid), 1);

    // Backpressure: result holds and start pulses are ignored.
    for (int i = 0; i < 5; i++) begin
      start   = (i % 2 == 0);
      win_len = 4'd3;
      @(negedge clk);
      check("bp_res_valid", 32'(res_valid), 1);
      check("bp_s_ready", 32'(s_ready), 0);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_release_res_valid", 32'(res_valid), 0);
    @(negedge clk);
    check("bp_start_ignored_busy", 32'(busy), 0);
    check("zero_len_go_rises", 32'(go_rises - rises0), 0);

    // Abort: reset while streaming.
    seen0   = res_seen;
    start   = 1'b1;
    win_len = 4'd4;
    @(negedge clk);
    start = 1'b0;
    exp_rf.push_back(8'd33);
    push_sample(8'd33);
    check("abort_in_stream", 32'(rf_go), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rf_go", 32'(rf_go), 0);
    check("abort_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_result", 32'(res_seen), 32'(seen0));

    // Recovery with the minimum one-sample window.
    smp[0] = 8'd50;
    run_window(1, 0, 1'b1, 3);

    check("final_res_queue", 32'(exp_res.size()), 0);
    check("final_rf_queue", 32'(exp_rf.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
